// File: rtl/priority_arbiter_n.sv
// N-way request arbiter with registered grant outputs and valid/ready handshake.
// Selects fixed priority (highest index wins) or round-robin (downward scan from ptr).
module priority_arbiter_n #(
  parameter  int unsigned N       = 8,
  parameter  int unsigned RR_MODE = 1,
  localparam int unsigned W       = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t      state, state_nx;
  logic        accept, load;
  logic [W-1:0] ptr, ptr_acc, start, win;
  int unsigned pos;

  always_comb begin
    accept   = (state == HOLD) && out_ready;
    ptr_acc  = (out_idx == '0) ? W'(N - 1) : out_idx - W'(1);
    // A winner loaded on the accept edge searches from the post-acceptance pointer.
    if (RR_MODE == 0)
      start = W'(N - 1);
    else
      start = accept ? ptr_acc : ptr;

    // Scan offsets far-to-near so the nearest set bit (offset 0 = start) overwrites last.
    win = '0;
    pos = 0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = int'(start) + k + 1;
      if (pos >= N) pos = pos - N;
      if (req[W'(pos)]) win = W'(pos);
    end

    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          load     = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (|req) load = 1'b1;
          else      state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
      ptr        <= W'(N - 1);
    end else begin
      state     <= state_nx;
      out_valid <= (state_nx == HOLD);
      if (accept) ptr <= ptr_acc;
      if (load) begin
        out_idx    <= win;
        out_onehot <= N'(1) << win;
      end else if (state_nx == IDLE) begin
        out_onehot <= '0;
      end
    end
  end

endmodule

// File: tb/tb_priority_arbiter_n.sv
// Bench for priority_arbiter_n: fixed-priority and round-robin instances driven in parallel
// and compared against a cycle-level behavioural model of the grant/accept protocol.
module tb_priority_arbiter_n;
  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] req = '0;
  logic         out_ready = 1'b0;
  logic         f_valid, r_valid;
  logic [2:0]   f_idx, r_idx;
  logic [N-1:0] f_oh, r_oh;

  int errors = 0;
  int checks = 0;

  // Model state per instance: index 0 = fixed priority, 1 = round-robin.
  bit          m_valid[2];
  int unsigned m_idx[2];
  int unsigned m_ptr[2];

  priority_arbiter_n #(.N(N), .RR_MODE(0)) u_fix (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .out_valid(f_valid), .out_idx(f_idx), .out_onehot(f_oh));

  priority_arbiter_n #(.N(N), .RR_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .out_valid(r_valid), .out_idx(r_idx), .out_onehot(r_oh));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1);
  end

  // First set bit met when walking from, from-1, ..., wrapping past 0 to N-1.
  function automatic int unsigned pick(logic [N-1:0] r, int unsigned from);
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned i = (from + N - k) % N;
      logic [2:0] b = 3'(i);
      if (r[b]) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_valid[m] = 1'b0;
      m_idx[m]   = 0;
      m_ptr[m]   = N - 1;
    end
  endtask

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      if (!(m_valid[m] && !out_ready)) begin
        if (m_valid[m]) m_ptr[m] = (m_idx[m] + N - 1) % N;
        if (req != '0) begin
          m_idx[m]   = pick(req, (m == 1) ? m_ptr[m] : N - 1);
          m_valid[m] = 1'b1;
        end else begin
          m_valid[m] = 1'b0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Asynchronous reset pulse starting mid-cycle, released on a falling edge.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req = '0; out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    checks++; if (f_valid !== 1'b0 || r_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b%b exp=00", f_valid, r_valid); end
    checks++; if (f_oh !== '0 || r_oh !== '0) begin errors++; $display("FAIL reset_onehot got=%h/%h exp=00/00", f_oh, r_oh); end
    @(posedge clk); @(posedge clk);
    #1;
    checks++; if (f_idx !== 3'd0 || r_idx !== 3'd0) begin errors++; $display("FAIL reset_idx got=%0d/%0d exp=0/0", f_idx, r_idx); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    req = 8'hFF; out_ready = 1'b1;
    tick();
    checks++; if (r_valid !== 1'b1 || r_idx !== 3'd7 || f_idx !== 3'd7) begin errors++; $display("FAIL reset_first_grant got=%b/%0d/%0d exp=1/7/7", r_valid, r_idx, f_idx); end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    req = 8'b0000_0111; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (f_valid !== 1'b1 || f_idx !== 3'd2) begin errors++; $display("FAIL fixed_idx[%0d] got=%b/%0d exp=1/2", i, f_valid, f_idx); end
      checks++; if (f_oh !== 8'b0000_0100) begin errors++; $display("FAIL fixed_onehot[%0d] got=%b exp=00000100", i, f_oh); end
    end
  endtask

  task automatic test_rr_sweep();
    int unsigned exp_seq[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    do_reset();
    req = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++; if (r_valid !== 1'b1 || r_idx !== 3'(exp_seq[i])) begin errors++; $display("FAIL rr_sweep[%0d] got=%b/%0d exp=1/%0d", i, r_valid, r_idx, exp_seq[i]); end
    end
  endtask

  task automatic test_rr_alternate();
    do_reset();
    req = 8'b1000_0001; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (r_valid !== 1'b1 || r_idx !== ((i % 2 == 0) ? 3'd7 : 3'd0)) begin errors++; $display("FAIL rr_alt[%0d] got=%b/%0d exp=1/%0d", i, r_valid, r_idx, (i % 2 == 0) ? 7 : 0); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 8'h20; out_ready = 1'b0;
    tick();
    req = 8'h01;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (r_valid !== 1'b1 || r_idx !== 3'd5 || r_oh !== 8'h20) begin errors++; $display("FAIL bp_hold_rr[%0d] got=%b/%0d/%h exp=1/5/20", i, r_valid, r_idx, r_oh); end
      checks++; if (f_valid !== 1'b1 || f_idx !== 3'd5) begin errors++; $display("FAIL bp_hold_fix[%0d] got=%b/%0d exp=1/5", i, f_valid, f_idx); end
    end
    out_ready = 1'b1;
    tick();
    checks++; if (r_valid !== 1'b1 || r_idx !== 3'd0 || f_idx !== 3'd0) begin errors++; $display("FAIL bp_release got=%b/%0d/%0d exp=1/0/0", r_valid, r_idx, f_idx); end
  endtask

  task automatic test_idle_single();
    do_reset();
    req = '0; out_ready = 1'b0;
    tick();
    checks++; if (r_valid !== 1'b0 || r_oh !== '0 || f_valid !== 1'b0 || f_oh !== '0) begin errors++; $display("FAIL idle got=%b/%h/%b/%h exp=0/00/0/00", r_valid, r_oh, f_valid, f_oh); end
    req = 8'b0000_1000;
    tick();
    req = '0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (r_valid !== 1'b1 || r_idx !== 3'd3 || r_oh !== 8'b0000_1000 || f_idx !== 3'd3) begin errors++; $display("FAIL single_hold[%0d] got=%b/%0d/%b/%0d exp=1/3/00001000/3", i, r_valid, r_idx, r_oh, f_idx); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++; if (r_valid !== 1'b0 || r_oh !== '0 || f_valid !== 1'b0) begin errors++; $display("FAIL single_to_idle got=%b/%h/%b exp=0/00/0", r_valid, r_oh, f_valid); end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 8'hFF; out_ready = 1'b1;
    tick(); tick(); tick();
    out_ready = 1'b0;
    tick();
    #3 rst_n = 1'b0;
    #1;
    checks++; if (r_valid !== 1'b0 || r_oh !== '0 || f_valid !== 1'b0) begin errors++; $display("FAIL async_reset got=%b/%h/%b exp=0/00/0", r_valid, r_oh, f_valid); end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req = 8'hFF; out_ready = 1'b1;
    tick();
    checks++; if (r_valid !== 1'b1 || r_idx !== 3'd7 || f_idx !== 3'd7) begin errors++; $display("FAIL post_reset_grant got=%b/%0d/%0d exp=1/7/7", r_valid, r_idx, f_idx); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req       = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom & $urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
      checks++; if (f_valid !== m_valid[0] || r_valid !== m_valid[1]) begin errors++; $display("FAIL rand_valid[%0d] got=%b/%b exp=%b/%b", i, f_valid, r_valid, m_valid[0], m_valid[1]); end
      checks++; if (f_oh !== (m_valid[0] ? N'(1) << m_idx[0] : '0) || r_oh !== (m_valid[1] ? N'(1) << m_idx[1] : '0)) begin errors++; $display("FAIL rand_onehot[%0d] got=%h/%h exp_idx=%0d/%0d", i, f_oh, r_oh, m_idx[0], m_idx[1]); end
      if (m_valid[0]) begin
        checks++; if (f_idx !== 3'(m_idx[0])) begin errors++; $display("FAIL rand_fix_idx[%0d] got=%0d exp=%0d", i, f_idx, m_idx[0]); end
      end
      if (m_valid[1]) begin
        checks++; if (r_idx !== 3'(m_idx[1])) begin errors++; $display("FAIL rand_rr_idx[%0d] got=%0d exp=%0d", i, r_idx, m_idx[1]); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fixed_priority();
    test_rr_sweep();
    test_rr_alternate();
    test_backpressure();
    test_idle_single();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
